instr_fetch: RTL and testbench

Fetch stage upstream of the instruction decoder. On a start request from the control unit it computes the next instruction address: sequential, relative jump, or reset vector. It then reads the 4-byte big-endian instruction over the byte-wide RAM bus with a req/ack handshake and presents the assembled word as the instruction register `ir` with a one-cycle `ir_valid` strobe.

---
 rtl/instr_fetch_pkg.sv | 25 ++
 rtl/instr_fetch_if.sv | 36 +++
 rtl/instr_fetch.sv | 192 +++++++++++++++++++
 tb/tb_instr_fetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkg_fetch (package)
// Purpose  : Shared types and constants for the instruction fetch stage.
//            - fetch_state_e : FSM state encoding
//            - FETCH_BYTES   : bytes per instruction word
//            - FETCH_TIMEOUT : wait-cycle limit before a fetch is abandoned
// Revision : 1.0 - initial release
// ============================================================================
package pkg_fetch;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_BUSY = 2'd1,
    FETCH_DONE = 2'd2,
    FETCH_ERR  = 2'd3
  } fetch_state_e;

  localparam int FETCH_BYTES   = 4;
  localparam int FETCH_TIMEOUT = 255;
  localparam int FETCH_CNT_W   = $clog2(FETCH_BYTES);
  localparam int FETCH_TMO_W   = 8;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Purpose  : Byte-wide RAM read bus with req/ack handshake.
// Signals  : ram_req  - byte read request (master -> slave)
//            ram_addr - byte address, stable while ram_req is high
//            ram_ack  - read data valid this cycle (slave -> master)
//            ram_data - read byte, taken when ram_req && ram_ack
// Modports : master (fetch stage), slave (RAM)
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int ADDR_W = 16
) ();

  logic              ram_req;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ack;
  logic [7:0]        ram_data;

  modport master (
    output ram_req,
    output ram_addr,
    input  ram_ack,
    input  ram_data
  );

  modport slave (
    input  ram_req,
    input  ram_addr,
    output ram_ack,
    output ram_data
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Fetch stage. On start, computes the next instruction address
//            (reset vector, relative jump or ip+4), reads the 4-byte
//            big-endian word over the byte-wide RAM bus and presents it in
//            ir with a one-cycle ir_valid strobe.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            start_i         - fetch request, sampled only in IDLE
//            jmp_i           - next address is a relative jump
//            jmp_offset_i    - signed jump distance in instructions
//            ram_bus         - RAM read bus (master modport)
//            ir_o            - instruction register
//            ir_valid_o      - strobe: ir/ip updated this cycle
//            ip_o            - address of the instruction in ir
//            busy_o          - fetch in progress, start ignored
//            fetch_err_o     - sticky fetch timeout
// Config   : FETCH_TIMEOUT_EN - when defined, a wait-cycle counter aborts a
//            fetch into a sticky ERR state; otherwise fetch_err_o is 0 and
//            the block waits for ack indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
  import pkg_fetch::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_IP = '0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              start_i,
  input  wire logic              jmp_i,
  input  wire logic [23:0]       jmp_offset_i,
  instr_fetch_if.master          ram_bus,
  output logic [31:0]            ir_o,
  output logic                   ir_valid_o,
  output logic [ADDR_W-1:0]      ip_o,
  output logic                   busy_o,
  output logic                   fetch_err_o
);

  localparam logic [FETCH_CNT_W-1:0] c_last_byte = FETCH_CNT_W'(FETCH_BYTES - 1);
  localparam logic [ADDR_W-1:0]      c_reset_vec = {RESET_IP[ADDR_W-1:2], 2'b00};

  fetch_state_e                  state_q, state_d;
  logic [FETCH_CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]             target_q, target_d;
  logic [8*(FETCH_BYTES-1)-1:0]  buf_q, buf_d;
  logic [31:0]                   ir_q, ir_d;
  logic [ADDR_W-1:0]             ip_q, ip_d;
  logic                          first_q, first_d;
`ifdef FETCH_TIMEOUT_EN
  logic [FETCH_TMO_W-1:0]        tmo_q, tmo_d;
`endif

  // Address candidates. The jump offset counts instructions, so it is
  // scaled by 4 and sign-extended (or truncated) to the address width.
  logic [ADDR_W-1:0] w_jmp_off;
  logic [ADDR_W-1:0] w_seq_addr;
  logic [ADDR_W-1:0] w_jmp_addr;

  assign w_jmp_off  = ADDR_W'($signed({jmp_offset_i, 2'b00}));
  assign w_seq_addr = ip_q + ADDR_W'(4);
  assign w_jmp_addr = ip_q + w_jmp_off;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      buf_q    <= '0;
      ir_q     <= '0;
      ip_q     <= '0;
      first_q  <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      buf_q    <= buf_d;
      ir_q     <= ir_d;
      ip_q     <= ip_d;
      first_q  <= first_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    buf_d    = buf_q;
    ir_d     = ir_q;
    ip_d     = ip_q;
    first_d  = first_q;
`ifdef FETCH_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif

    case (state_q)
      FETCH_IDLE: begin
        if (start_i) begin
          state_d = FETCH_BUSY;
          cnt_d   = '0;
          first_d = 1'b0;
          if (first_q) begin
            target_d = c_reset_vec;
          end else if (jmp_i) begin
            target_d = w_jmp_addr;
          end else begin
            target_d = w_seq_addr;
          end
`ifdef FETCH_TIMEOUT_EN
          tmo_d = '0;
`endif
        end
      end

      FETCH_BUSY: begin
        if (ram_bus.ram_ack) begin
          // Bytes shift in from the right so byte 0 ends up in ir[31:24].
          buf_d = {buf_q[8*(FETCH_BYTES-2)-1:0], ram_bus.ram_data};
          cnt_d = cnt_q + FETCH_CNT_W'(1);
          // ir/ip load on the edge entering DONE so they are already valid
          // while ir_valid is high; partial words never reach ir.
          if (cnt_q == c_last_byte) begin
            ir_d    = {buf_q, ram_bus.ram_data};
            ip_d    = target_q;
            state_d = FETCH_DONE;
          end
`ifdef FETCH_TIMEOUT_EN
          tmo_d = '0;
`endif
        end else begin
`ifdef FETCH_TIMEOUT_EN
          tmo_d = tmo_q + FETCH_TMO_W'(1);
          if (tmo_d == FETCH_TMO_W'(FETCH_TIMEOUT)) begin
            state_d = FETCH_ERR;
          end
`endif
        end
      end

      FETCH_DONE: begin
        state_d = FETCH_IDLE;
      end

      FETCH_ERR: begin
`ifdef FETCH_TIMEOUT_EN
        // Sticky: only reset leaves ERR.
        state_d = FETCH_ERR;
`else
        state_d = FETCH_IDLE;
`endif
      end

      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs. ram_req decodes the state register directly so that an
  // asynchronous reset drops it immediately.
  // ---------------------------------------------------------------------
  assign ram_bus.ram_req  = (state_q == FETCH_BUSY);
  assign ram_bus.ram_addr = target_q + ADDR_W'(cnt_q);

  assign ir_o       = ir_q;
  assign ip_o       = ip_q;
  assign ir_valid_o = (state_q == FETCH_DONE);
  assign busy_o     = (state_q != FETCH_IDLE);

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err_o = (state_q == FETCH_ERR);
`else
  assign fetch_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch. A byte-array RAM answers
//            the bus with per-byte programmable wait states; a reference
//            model computes the next address and the expected big-endian
//            word and latency with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int          ADDR_W   = 16;
  localparam logic [15:0] RESET_IP = 16'h0010;

  logic        clk;
  logic        rst;
  logic        start;
  logic        jmp;
  logic [23:0] jmp_offset;
  logic [31:0] ir;
  logic        ir_valid;
  logic [15:0] ip;
  logic        busy;
  logic        fetch_err;

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_IP (RESET_IP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .jmp_i        (jmp),
    .jmp_offset_i (jmp_offset),
    .ram_bus      (bus.master),
    .ir_o         (ir),
    .ir_valid_o   (ir_valid),
    .ip_o         (ip),
    .busy_o       (busy),
    .fetch_err_o  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM responder ----------------
  logic [7:0]  mem [0:65535];
  int          byte_wait [4];
  int          stall;
  int          ack_idx;
  logic        ack_en;
  logic        spur_ack;
  logic [15:0] addr_log [$];

  assign bus.ram_data = mem[bus.ram_addr];
  assign bus.ram_ack  = bus.ram_req ? (ack_en && (stall >= byte_wait[ack_idx])) : spur_ack;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stall   <= 0;
      ack_idx <= 0;
    end else if (bus.ram_req) begin
      if (bus.ram_ack) begin
        addr_log.push_back(bus.ram_addr);
        stall   <= 0;
        ack_idx <= (ack_idx + 1) % 4;
      end else begin
        stall <= stall + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  bit          m_first;
  logic [15:0] m_ip;
  logic [31:0] m_ir;

  task automatic model_reset();
    m_first = 1'b1;
    m_ip    = 16'h0;
    m_ir    = 32'h0;
  endtask

  function automatic logic [15:0] next_target(input bit j, input logic [23:0] off);
    int so;
    if (m_first) return RESET_IP & 16'hFFFC;
    if (!j) return 16'(int'(m_ip) + 4);
    so = int'($signed(off));
    return 16'(int'(m_ip) + so * 4);
  endfunction

  function automatic logic [31:0] word_at(input logic [15:0] a);
    logic [15:0] a1, a2, a3;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    a3 = a + 16'd3;
    return {mem[a], mem[a1], mem[a2], mem[a3]};
  endfunction

  // One complete fetch: start, wait for ir_valid (random start pulses and
  // jump noise while busy), then check word, address, latency and hold.
  task automatic do_fetch(input bit j, input logic [23:0] off);
    logic [15:0] tgt;
    logic [31:0] exp_ir;
    int          exp_lat;
    int          n;
    int          base;
    tgt     = next_target(j, off);
    exp_ir  = word_at(tgt);
    exp_lat = 5 + byte_wait[0] + byte_wait[1] + byte_wait[2] + byte_wait[3];
    base    = addr_log.size();

    start      = 1'b1;
    jmp        = j;
    jmp_offset = off;
    spur_ack   = 1'b0;
    tick();
    start = 1'b0;
    n = 1;
    check_eq("busy_c1", {31'b0, busy}, 32'd1);
    check_eq("req_c1", {31'b0, bus.ram_req}, 32'd1);
    while (!ir_valid && n < 80) begin
      check_eq("ir_atomic", ir, m_ir);
      start      = 1'($urandom_range(0, 1));
      jmp        = 1'($urandom_range(0, 1));
      jmp_offset = 24'($urandom);
      tick();
      n++;
    end
    start = 1'b0;
    check_eq("latency", 32'(n), 32'(exp_lat));
    check_eq("ir", ir, exp_ir);
    check_eq("ip", {16'b0, ip}, {16'b0, tgt});
    check_eq("busy_done", {31'b0, busy}, 32'd1);
    check_eq("fetch_err", {31'b0, fetch_err}, 32'd0);
    check_eq("addr_cnt", 32'(addr_log.size() - base), 32'd4);
    for (int i = 0; i < 4 && base + i < addr_log.size(); i++) begin
      check_eq("addr", {16'b0, addr_log[base+i]}, {16'b0, 16'(tgt + 16'(i))});
    end
    m_ir    = exp_ir;
    m_ip    = tgt;
    m_first = 1'b0;

    spur_ack = 1'($urandom_range(0, 1));
    tick();
    check_eq("valid_drop", {31'b0, ir_valid}, 32'd0);
    check_eq("busy_idle", {31'b0, busy}, 32'd0);
    check_eq("ir_hold", ir, m_ir);
    check_eq("ip_hold", {16'b0, ip}, {16'b0, m_ip});
  endtask

  task automatic set_waits(input int w0, input int w1, input int w2, input int w3);
    byte_wait[0] = w0;
    byte_wait[1] = w1;
    byte_wait[2] = w2;
    byte_wait[3] = w3;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    jmp        = 1'b0;
    jmp_offset = 24'h0;
    ack_en     = 1'b1;
    spur_ack   = 1'b0;
    set_waits(0, 0, 0, 0);
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'h01;
    mem[16'h0011] = 8'h2A;
    mem[16'h0012] = 8'h00;
    mem[16'h0013] = 8'h00;
    model_reset();

    tick();
    tick();
    check_eq("rst_req", {31'b0, bus.ram_req}, 32'd0);
    check_eq("rst_addr", {16'b0, bus.ram_addr}, 32'd0);
    check_eq("rst_ir", ir, 32'h0);
    check_eq("rst_valid", {31'b0, ir_valid}, 32'd0);
    check_eq("rst_ip", {16'b0, ip}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_err", {31'b0, fetch_err}, 32'd0);
    rst = 1'b0;
    tick();

    // First fetch from the reset vector; jmp must be ignored.
    do_fetch(1'b1, 24'h000005);
    check_eq("first_word", ir, 32'h012A0000);
    do_fetch(1'b0, 24'h0);                 // 0x14
    do_fetch(1'b0, 24'h0);                 // 0x18
    do_fetch(1'b0, 24'h0);                 // 0x1C
    do_fetch(1'b0, 24'h0);                 // 0x20
    do_fetch(1'b1, 24'hFFFFFE);            // back to 0x18
    check_eq("jmp_back", {16'b0, ip}, 32'h0018);
    do_fetch(1'b1, 24'h003FF9);            // 0xFFFC
    do_fetch(1'b1, 24'h000001);            // wraps to 0x0000
    check_eq("jmp_wrap", {16'b0, ip}, 32'h0000);
    do_fetch(1'b1, 24'hFFFFFF);            // 0xFFFC
    do_fetch(1'b0, 24'h0);                 // sequential wrap to 0x0000

    // Three wait states on byte 2.
    set_waits(0, 0, 3, 0);
    do_fetch(1'b0, 24'h0);

    // Randomized fetches.
    for (int k = 0; k < 24; k++) begin
      set_waits($urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      do_fetch(1'($urandom_range(0, 1)), 24'($urandom));
    end

    // Reset in cycle 3 of a fetch.
    set_waits(0, 0, 0, 0);
    start = 1'b1;
    jmp   = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_eq("req_before_rst", {31'b0, bus.ram_req}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_req", {31'b0, bus.ram_req}, 32'd0);
    check_eq("rst_mid_ir", ir, 32'h0);
    check_eq("rst_mid_ip", {16'b0, ip}, 32'd0);
    check_eq("rst_mid_busy", {31'b0, busy}, 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    do_fetch(1'b1, 24'h000123);            // from RESET_IP again
    check_eq("post_rst_ip", {16'b0, ip}, 32'h0010);

`ifdef FETCH_TIMEOUT_EN
    begin
      int n;
      ack_en = 1'b0;
      start  = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (!fetch_err && n < 400) begin
        tick();
        n++;
      end
      check_eq("tmo_cycles", 32'(n), 32'd256);
      check_eq("tmo_req", {31'b0, bus.ram_req}, 32'd0);
      check_eq("tmo_ir", ir, m_ir);
      check_eq("tmo_valid", {31'b0, ir_valid}, 32'd0);
      check_eq("tmo_busy", {31'b0, busy}, 32'd1);
    end
`else
    check_eq("no_tmo_err", {31'b0, fetch_err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
